// File: rtl/conv_job_arbiter.sv
// Round-robin arbiter sharing one circular-convolution engine between N_REQ requesters.
// Latches the winner's operands, issues the engine, waits with a watchdog and returns the result.
module conv_job_arbiter #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned QLEN        = 16,
   parameter int unsigned WINDOW_SIZE = 16,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N_REQ-1:0]                   req_valid,
   output logic [N_REQ-1:0]                   req_ready,
   input  logic [N_REQ*WINDOW_SIZE*QLEN-1:0]  req_data,
   input  logic [N_REQ*WINDOW_SIZE*QLEN-1:0]  req_weights,
   output logic [N_REQ-1:0]                   rsp_valid,
   input  logic [N_REQ-1:0]                   rsp_ready,
   output logic [WINDOW_SIZE*QLEN-1:0]        rsp_data,
   output logic                               rsp_err,
   output logic                               eng_in_valid,
   output logic [WINDOW_SIZE*QLEN-1:0]        eng_in_data,
   output logic [WINDOW_SIZE*QLEN-1:0]        eng_weights,
   input  logic                               eng_out_valid,
   input  logic [WINDOW_SIZE*QLEN-1:0]        eng_out_data,
   output logic                               busy,
   output logic [$clog2(N_REQ)-1:0]           grant_id
);

   localparam int unsigned DW = WINDOW_SIZE * QLEN;
   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   rr_ptr;
   logic            issue_second;
   logic [CW-1:0]   wait_cnt;
   logic            win_found;
   logic [IW-1:0]   winner;
   int unsigned     scan_idx;
   logic [DW-1:0]   sel_data, sel_weights;
   logic            timeout_hit, rsp_hs;

   // Round-robin scan starting at rr_ptr
   always_comb begin
      win_found = 1'b0;
      winner    = '0;
      scan_idx  = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         scan_idx = (32'(rr_ptr) + i) % N_REQ;
         if (!win_found && req_valid[IW'(scan_idx)]) begin
            win_found = 1'b1;
            winner    = IW'(scan_idx);
         end
      end
   end

   always_comb begin
      sel_data    = '0;
      sel_weights = '0;
      for (int unsigned r = 0; r < N_REQ; r++) begin
         if (32'(winner) == r) begin
            sel_data    = req_data[r*DW +: DW];
            sel_weights = req_weights[r*DW +: DW];
         end
      end
   end

   assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
   assign rsp_hs      = rsp_ready[grant_id];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      req_ready    = '0;
      rsp_valid    = '0;
      eng_in_valid = 1'b0;
      busy         = (state != IDLE);
      case (state)
         IDLE: begin
            if (win_found) begin
               req_ready[winner] = 1'b1;
               state_nxt         = ISSUE;
            end
         end
         ISSUE: begin
            eng_in_valid = 1'b1;
            if (issue_second) state_nxt = WAIT;
         end
         WAIT: begin
            if (eng_out_valid || timeout_hit) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid[grant_id] = 1'b1;
            if (rsp_hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, watchdog, result capture and pointer advance
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr       <= '0;
         grant_id     <= '0;
         issue_second <= 1'b0;
         wait_cnt     <= '0;
         eng_in_data  <= '0;
         eng_weights  <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  eng_in_data  <= sel_data;
                  eng_weights  <= sel_weights;
                  grant_id     <= winner;
                  issue_second <= 1'b0;
               end
            end
            ISSUE: begin
               issue_second <= 1'b1;
               wait_cnt     <= '0;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + CW'(1);
               if (eng_out_valid) begin
                  rsp_data <= eng_out_data;
                  rsp_err  <= 1'b0;
               end else if (timeout_hit) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_hs)
                  rr_ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_job_arbiter.sv
// Scoreboard bench for conv_job_arbiter: an engine stub, a queue-based reference arbiter
// and directed plus randomized job streams.
module tb_conv_job_arbiter;

   localparam int N_REQ   = 4;
   localparam int QLEN    = 16;
   localparam int WS      = 16;
   localparam int TIMEOUT = 64;
   localparam int DW      = WS * QLEN;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N_REQ-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N_REQ*DW-1:0]     req_data, req_weights;
   logic [DW-1:0]           rsp_data, eng_in_data, eng_weights, eng_out_data;
   logic                    rsp_err, eng_in_valid, eng_out_valid, busy;
   logic [1:0]              grant_id;

   always #5 clk = ~clk;

   conv_job_arbiter #(.N_REQ(N_REQ), .QLEN(QLEN), .WINDOW_SIZE(WS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_weights(req_weights),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .eng_in_valid(eng_in_valid), .eng_in_data(eng_in_data), .eng_weights(eng_weights),
      .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
      .busy(busy), .grant_id(grant_id)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Circular convolution y[k] = sum_j x[j]*w[(k-j) mod WS], truncated to QLEN
   function automatic logic [DW-1:0] conv(input logic [DW-1:0] x, input logic [DW-1:0] w);
      logic [DW-1:0]   y;
      logic [QLEN-1:0] acc, xe, we;
      y = '0;
      for (int k = 0; k < WS; k++) begin
         acc = '0;
         for (int j = 0; j < WS; j++) begin
            xe  = x[j*QLEN +: QLEN];
            we  = w[((k - j + WS) % WS)*QLEN +: QLEN];
            acc = acc + xe * we;
         end
         y[k*QLEN +: QLEN] = acc;
      end
      return y;
   endfunction

   // Engine response delay is encoded in the top byte of the window: 0 nominal, 255 never
   function automatic int delay_of(input logic [DW-1:0] x);
      logic [7:0] code;
      code = x[DW-1 -: 8];
      if (code == 8'd0)   return WS + 1;
      if (code == 8'hFF)  return -1;
      return int'(code) - 1;
   endfunction

   function automatic int stub_cnt(input logic [DW-1:0] x);
      int d;
      d = delay_of(x);
      return (d < 0) ? 0 : d + 1;
   endfunction

   // Engine stub: samples on the second consecutive in_valid cycle
   int            eng_cnt;
   logic          eng_prev;
   logic [DW-1:0] eng_res;
   always @(posedge clk) begin
      if (rst) begin
         eng_cnt  <= 0;
         eng_prev <= 1'b0;
         eng_res  <= '0;
      end else begin
         eng_prev <= eng_in_valid;
         if (eng_in_valid && eng_prev) begin
            eng_cnt <= stub_cnt(eng_in_data);
            eng_res <= conv(eng_in_data, eng_weights);
         end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
         end
      end
   end
   assign eng_out_valid = (eng_cnt == 1);
   assign eng_out_data  = eng_out_valid ? eng_res : ~eng_res;

   typedef struct {
      int            id;
      logic [DW-1:0] in_d;
      logic [DW-1:0] in_w;
      logic [DW-1:0] res;
      logic          err;
      int            lat;
   } exp_t;

   exp_t          sb[$];
   int            acc_log[$];
   logic [DW-1:0] cur_data [N_REQ];
   logic [DW-1:0] cur_w    [N_REQ];
   int            starve_cnt [N_REQ];
   bit            m_busy = 1'b0;
   int            m_ptr = 0;
   int            acc_id = -1;
   int            resp_done = 0;
   int            lat_cnt = 0;
   bit            first_seen = 1'b0;
   int            mon_win, mon_idx, mon_d;
   logic [N_REQ-1:0] mon_exp;
   exp_t          mon_e;

   // Reference arbiter and response monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         m_busy = 1'b0;
         m_ptr  = 0;
         acc_id = -1;
         for (int r = 0; r < N_REQ; r++) starve_cnt[r] = 0;
      end else begin
         check("busy", DW'(busy), DW'(m_busy));
         if (!m_busy) begin
            mon_win = -1;
            for (int i = 0; i < N_REQ; i++) begin
               mon_idx = (m_ptr + i) % N_REQ;
               if (mon_win < 0 && req_valid[mon_idx]) mon_win = mon_idx;
            end
            mon_exp = '0;
            if (mon_win >= 0) mon_exp[mon_win] = 1'b1;
            check("req_ready", DW'(req_ready), DW'(mon_exp));
            check("rsp_valid_idle", DW'(rsp_valid), '0);
            check("eng_in_valid_idle", DW'(eng_in_valid), '0);
            if (mon_win >= 0) begin
               check("starvation", DW'(starve_cnt[mon_win] <= N_REQ - 1), DW'(1));
               for (int r = 0; r < N_REQ; r++)
                  if (r != mon_win && req_valid[r]) starve_cnt[r]++;
               starve_cnt[mon_win] = 0;
               mon_d      = delay_of(cur_data[mon_win]);
               mon_e.id   = mon_win;
               mon_e.in_d = cur_data[mon_win];
               mon_e.in_w = cur_w[mon_win];
               mon_e.err  = (mon_d < 0) || (mon_d >= TIMEOUT);
               mon_e.res  = mon_e.err ? '0 : conv(cur_data[mon_win], cur_w[mon_win]);
               mon_e.lat  = (mon_e.err ? TIMEOUT - 1 : mon_d) + 4;
               sb.push_back(mon_e);
               acc_log.push_back(mon_win);
               acc_id     = mon_win;
               m_busy     = 1'b1;
               lat_cnt    = 0;
               first_seen = 1'b0;
            end
         end else if (sb.size() == 0) begin
            check("sb_empty_busy", DW'(sb.size()), DW'(1));
         end else begin
            lat_cnt++;
            mon_e = sb[0];
            check("req_ready_busy", DW'(req_ready), '0);
            check("eng_in_valid", DW'(eng_in_valid), DW'(lat_cnt == 1 || lat_cnt == 2));
            check("eng_in_data", eng_in_data, mon_e.in_d);
            check("eng_weights", eng_weights, mon_e.in_w);
            if (rsp_valid != '0) begin
               mon_exp = '0;
               mon_exp[mon_e.id] = 1'b1;
               check("rsp_valid", DW'(rsp_valid), DW'(mon_exp));
               check("rsp_data", rsp_data, mon_e.res);
               check("rsp_err", DW'(rsp_err), DW'(mon_e.err));
               check("grant_id", DW'(grant_id), DW'(mon_e.id));
               if (!first_seen) check("latency", DW'(lat_cnt), DW'(mon_e.lat));
               first_seen = 1'b1;
               if (rsp_ready[mon_e.id]) begin
                  void'(sb.pop_front());
                  m_busy = 1'b0;
                  m_ptr  = (mon_e.id + 1) % N_REQ;
                  resp_done++;
               end
            end
         end
      end
   end

   int p_req    = 0;
   int rdy_pct  = 100;
   int to_issue = 0;

   task automatic offer(input int r, input logic [DW-1:0] d, input logic [DW-1:0] w);
      cur_data[r] = d;
      cur_w[r]    = w;
      req_data[r*DW +: DW]    = d;
      req_weights[r*DW +: DW] = w;
      req_valid[r] = 1'b1;
   endtask

   task automatic make_job(input int code, output logic [DW-1:0] d, output logic [DW-1:0] w);
      int sel, c;
      for (int i = 0; i < DW / 32; i++) begin
         d[i*32 +: 32] = $urandom;
         w[i*32 +: 32] = $urandom;
      end
      c = code;
      if (c < 0) begin
         sel = int'($urandom_range(0, 99));
         if      (sel < 80) c = 0;
         else if (sel < 84) c = 1;
         else if (sel < 87) c = 64;
         else if (sel < 90) c = 65;
         else if (sel < 92) c = 255;
         else if (sel < 94) c = 100;
         else               c = int'($urandom_range(2, 40));
      end
      d[DW-1 -: 8] = 8'(c);
   endtask

   task automatic step();
      logic [DW-1:0] d, w;
      @(posedge clk);
      #1;
      if (acc_id >= 0) begin
         req_valid[acc_id] = 1'b0;
         acc_id = -1;
      end
      for (int r = 0; r < N_REQ; r++) begin
         if (!req_valid[r] && to_issue > 0 && int'($urandom_range(0, 99)) < p_req) begin
            make_job(-1, d, w);
            offer(r, d, w);
            to_issue--;
         end
         rsp_ready[r] = int'($urandom_range(0, 99)) < rdy_pct;
      end
   endtask

   task automatic run_until(input int target, input int budget);
      int c = 0;
      while (resp_done < target && c < budget) begin
         step();
         c++;
      end
      check("jobs_done", DW'(resp_done), DW'(target));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rsp_valid"}, DW'(rsp_valid), '0);
      check({tag, "_req_ready"}, DW'(req_ready), '0);
      check({tag, "_busy"}, DW'(busy), '0);
      check({tag, "_grant_id"}, DW'(grant_id), '0);
      check({tag, "_eng_in_valid"}, DW'(eng_in_valid), '0);
      check({tag, "_rsp_err"}, DW'(rsp_err), '0);
      check({tag, "_rsp_data"}, rsp_data, '0);
      check({tag, "_eng_in_data"}, eng_in_data, '0);
      check({tag, "_eng_weights"}, eng_weights, '0);
   endtask

   initial begin
      logic [DW-1:0] d, w;
      int s, c, tgt;
      int codes [5];
      codes = '{255, 0, 64, 65, 0};

      rst = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_data = '0;
      req_weights = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // Single job on requester 0 with identity weights
      d = '0;
      w = '0;
      for (int i = 0; i < WS; i++) d[i*QLEN +: QLEN] = QLEN'(i + 1);
      w[0 +: QLEN] = QLEN'(1);
      rdy_pct = 100;
      offer(0, d, w);
      run_until(resp_done + 1, 200);

      // All requesters busy: grant order follows the pointer
      do_reset();
      s = acc_log.size();
      p_req = 100;
      to_issue = 8;
      run_until(resp_done + 8, 2000);
      p_req = 0;
      for (int i = 0; i < 8; i++)
         check("rr_order", DW'(acc_log.size() > s + i ? acc_log[s + i] : -1), DW'(i % N_REQ));

      // Response back-pressure on requester 2 while others request
      rdy_pct = 0;
      tgt = resp_done + 3;
      make_job(0, d, w);
      offer(2, d, w);
      s = acc_log.size();
      c = 0;
      while (acc_log.size() == s && c < 50) begin step(); c++; end
      make_job(0, d, w); offer(0, d, w);
      make_job(0, d, w); offer(1, d, w);
      c = 0;
      while (rsp_valid[2] !== 1'b1 && c < 200) begin step(); c++; end
      check("hold_rsp_valid", DW'(rsp_valid), DW'(4'b0100));
      repeat (10) step();
      check("hold_rsp_valid_end", DW'(rsp_valid), DW'(4'b0100));
      rdy_pct = 100;
      run_until(tgt, 500);

      // Engine silence, timeout boundary and recovery
      for (int i = 0; i < 5; i++) begin
         make_job(codes[i], d, w);
         offer(1, d, w);
         run_until(resp_done + 1, 300);
      end

      // Reset during WAIT
      make_job(0, d, w);
      offer(3, d, w);
      s = acc_log.size();
      c = 0;
      while (acc_log.size() == s && c < 50) begin step(); c++; end
      repeat (7) step();
      rst = 1'b1;
      step();
      check_all_zero("midrst");
      rst = 1'b0;
      for (int r = 0; r < N_REQ; r++) begin
         make_job(0, d, w);
         offer(r, d, w);
      end
      s = acc_log.size();
      run_until(resp_done + 4, 500);
      check("rr_after_rst", DW'(acc_log.size() > s ? acc_log[s] : -1), '0);

      // Randomized traffic
      rdy_pct = 70;
      p_req = 30;
      to_issue = 1000;
      run_until(resp_done + 1000, 80000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
